// File: rtl/fir_pkg.sv
// fir_pkg: shared types, FSM states and coefficients for the time-shared
// FIR arbiter (fir_share_arb) and its filter core (FIR_Filter_Core).
package fir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR0,
        ST_CLR1,
        ST_FEED,
        ST_CAP,
        ST_RESP
    } fir_state_e;

    typedef logic [2:0]  fir_sample_t;
    typedef logic [11:0] fir_result_t;

    localparam int unsigned FIR_TAPS   = 3;
    localparam int unsigned FIR_MAX_CH = 4;

    localparam fir_result_t FIR_C0 = 12'd50;
    localparam fir_result_t FIR_C1 = 12'd31;
    localparam fir_result_t FIR_C2 = 12'd63;

    // Largest result is 144 * 7 = 1008, so the 12-bit sum never wraps.
    function automatic fir_result_t fir_mac(input fir_sample_t x0,
                                            input fir_sample_t x1,
                                            input fir_sample_t x2);
        return FIR_C0 * fir_result_t'(x0)
             + FIR_C1 * fir_result_t'(x1)
             + FIR_C2 * fir_result_t'(x2);
    endfunction

endpackage

// File: rtl/fir_share_arb_core.sv
// FIR_Filter_Core: 3-tap FIR, y = 50*x[n] + 31*x[n-1] + 63*x[n-2],
// with a registered output one cycle after Xin is presented.
module FIR_Filter_Core
    import fir_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  fir_sample_t Xin,
    output fir_result_t Yout
);

    fir_sample_t tap1;
    fir_sample_t tap2;

    // Registered MAC over the current input and the two delayed taps
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tap1 <= '0;
            tap2 <= '0;
            Yout <= '0;
        end else begin
            Yout <= fir_mac(Xin, tap1, tap2);
            tap1 <= Xin;
            tap2 <= tap1;
        end
    end

endmodule

// File: rtl/fir_share_arb.sv
// fir_share_arb: shares one FIR_Filter_Core across NCH requester channels.
// Each channel keeps a private 3-sample history; a job clears the core taps,
// replays the channel's valid history oldest first, captures the result and
// holds it until accepted.
// Build option: define FIR_ARB_FIXED_PRIO_EN for fixed priority (channel 0
// highest) instead of the default round-robin arbitration.
module fir_share_arb
    import fir_pkg::*;
#(
    parameter int unsigned NCH = 2
)(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NCH-1:0]      i_vld,
    input  logic [NCH-1:0][2:0] i_x,
    output logic [NCH-1:0]      o_rdy,
    output logic [11:0]         o_y,
    output logic [1:0]          o_y_ch,
    output logic                o_y_vld,
    input  logic                i_y_rdy,
    output logic                o_err
);

    fir_state_e            state;
    fir_sample_t           hist [FIR_MAX_CH][FIR_TAPS];
    logic [FIR_TAPS-1:0]   hvld [FIR_MAX_CH];
    logic [1:0]            gnt_ch;
    logic [1:0]            feed_idx;
`ifndef FIR_ARB_FIXED_PRIO_EN
    logic [1:0]            rr_ptr;
`endif

    logic [FIR_MAX_CH-1:0] vld_pad;
    fir_sample_t           x_pad [FIR_MAX_CH];
    logic                  gnt_found;
    logic [1:0]            gnt_next;
    logic [NCH-1:0]        rdy_next;
    fir_sample_t           core_x;
    fir_result_t           core_y;

    // Widen the channel inputs to the fixed slot count so 2-bit indices fit
    always_comb begin
        vld_pad = '0;
        for (int unsigned c = 0; c < FIR_MAX_CH; c++) begin
            x_pad[c] = '0;
        end
        for (int unsigned c = 0; c < NCH; c++) begin
            vld_pad[c] = i_vld[c];
            x_pad[c]   = i_x[c];
        end
    end

    // Choose the next channel to grant among those presenting a sample
    always_comb begin
`ifndef FIR_ARB_FIXED_PRIO_EN
        int unsigned slot;
        slot      = 0;
`endif
        gnt_found = 1'b0;
        gnt_next  = '0;
`ifdef FIR_ARB_FIXED_PRIO_EN
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!gnt_found && vld_pad[2'(i)]) begin
                gnt_found = 1'b1;
                gnt_next  = 2'(i);
            end
        end
`else
        for (int unsigned i = 0; i < NCH; i++) begin
            slot = 32'(rr_ptr) + i;
            if (slot >= NCH) begin
                slot = slot - NCH;
            end
            if (!gnt_found && vld_pad[2'(slot)]) begin
                gnt_found = 1'b1;
                gnt_next  = 2'(slot);
            end
        end
`endif
        rdy_next = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            rdy_next[c] = (2'(c) == gnt_next);
        end
    end

    // Core input is the selected history entry during FEED, zero otherwise
    always_comb begin
        core_x = '0;
        if (state == ST_FEED) begin
            core_x = hist[gnt_ch][feed_idx];
        end
    end

    FIR_Filter_Core u_core (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .Xin     (core_x),
        .Yout    (core_y)
    );

    // Arbitration, per-channel history and job sequencing
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            gnt_ch   <= '0;
            feed_idx <= '0;
`ifndef FIR_ARB_FIXED_PRIO_EN
            rr_ptr   <= '0;
`endif
            o_rdy    <= '0;
            o_y      <= '0;
            o_y_ch   <= '0;
            o_y_vld  <= 1'b0;
            o_err    <= 1'b0;
            for (int unsigned c = 0; c < FIR_MAX_CH; c++) begin
                hvld[c] <= '0;
                for (int unsigned t = 0; t < FIR_TAPS; t++) begin
                    hist[c][t] <= '0;
                end
            end
        end else begin
            o_rdy <= '0;
            o_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Grant edge raises o_rdy; the sample transfers on the
                    // following edge while o_rdy is high. o_err flags a zero
                    // sample, which is consumed without touching history.
                    if (o_rdy != '0) begin
                        if (!o_err) begin
                            hist[gnt_ch][0] <= x_pad[gnt_ch];
                            hist[gnt_ch][1] <= hist[gnt_ch][0];
                            hist[gnt_ch][2] <= hist[gnt_ch][1];
                            hvld[gnt_ch]    <= {hvld[gnt_ch][1:0], 1'b1};
                            state           <= ST_CLR0;
                        end
                    end else if (gnt_found) begin
                        o_rdy  <= rdy_next;
                        gnt_ch <= gnt_next;
                        o_err  <= (x_pad[gnt_next] == '0);
`ifndef FIR_ARB_FIXED_PRIO_EN
                        rr_ptr <= (32'(gnt_next) + 32'd1 >= NCH) ? 2'd0 : gnt_next + 2'd1;
`endif
                    end
                end
                ST_CLR0: begin
                    state <= ST_CLR1;
                end
                ST_CLR1: begin
                    // Valid entries are contiguous from the newest, so the
                    // oldest valid index is the count of valid bits minus one.
                    feed_idx <= 2'({1'b0, hvld[gnt_ch][0]} + {1'b0, hvld[gnt_ch][1]}
                                 + {1'b0, hvld[gnt_ch][2]} - 2'd1);
                    state    <= ST_FEED;
                end
                ST_FEED: begin
                    if (feed_idx == '0) begin
                        state <= ST_CAP;
                    end else begin
                        feed_idx <= feed_idx - 2'd1;
                    end
                end
                ST_CAP: begin
                    o_y     <= core_y;
                    o_y_ch  <= gnt_ch;
                    o_y_vld <= 1'b1;
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_y_rdy) begin
                        o_y_vld <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_share_arb.sv
// tb_fir_share_arb: self-checking bench for fir_share_arb. Per-channel sample
// queues drive the inputs; a reference model tracks channel histories,
// arbitration order, result values and result timing.
module tb_fir_share_arb;

    localparam int unsigned NCH  = 2;
    localparam int unsigned QMAX = 64;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic [NCH-1:0]      vld   = '0;
    logic [NCH-1:0][2:0] x     = '0;
    logic [NCH-1:0]      rdy;
    logic [11:0]         y;
    logic [1:0]          ych;
    logic                yvld;
    logic                yrdy  = 1'b1;
    logic                err;

    fir_share_arb #(.NCH(NCH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_vld   (vld),
        .i_x     (x),
        .o_rdy   (rdy),
        .o_y     (y),
        .o_y_ch  (ych),
        .o_y_vld (yvld),
        .i_y_rdy (yrdy),
        .o_err   (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // stimulus queues
    int sbuf [NCH][QMAX];
    int head [NCH];
    int tail [NCH];
    bit consumed [NCH];

    // reference model
    int             mh [NCH][3];
    int             mk [NCH];
    int             mptr       = 0;
    logic [NCH-1:0] prev_vld   = '0;
    bit             busy       = 1'b0;
    int             cd         = 0;
    int             exp_y      = 0;
    int             exp_ch     = 0;
    int             stall_left = 0;
    bit             rand_stall = 1'b0;
    int             n_acc      = 0;
    int             n_err1     = 0;
    int             n_stall    = 0;
    int             res_log [$];
    int             grant_log [$];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NCH-1:0] req);
        int r = -1;
`ifdef FIR_ARB_FIXED_PRIO_EN
        for (int i = NCH - 1; i >= 0; i--) if (req[i]) r = i;
`else
        for (int i = NCH - 1; i >= 0; i--) begin
            int c = (mptr + i) % NCH;
            if (req[c]) r = c;
        end
`endif
        return r;
    endfunction

    function automatic int last_res();
        if (res_log.size() == 0) return -1;
        return res_log[res_log.size() - 1];
    endfunction

    function automatic bit pending();
        bit p = 1'b0;
        for (int c = 0; c < NCH; c++) if (head[c] < tail[c] || consumed[c]) p = 1'b1;
        return p;
    endfunction

    task automatic refresh();
        for (int c = 0; c < NCH; c++) begin
            vld[c] = (head[c] < tail[c]);
            x[c]   = vld[c] ? 3'(sbuf[c][head[c]]) : 3'd0;
        end
        yrdy = (stall_left == 0);
    endtask

    task automatic enqueue(input int c, input int v);
        if (tail[c] < QMAX) begin
            sbuf[c][tail[c]] = v;
            tail[c]++;
        end
        refresh();
    endtask

    // Called at the falling edge: compare DUT outputs against the model
    task automatic monitor();
        int g;
        int xs;
        if (busy && cd > 0) cd--;
        if (busy) check_eq("rdy_during_job", int'(rdy), 0);
        check_eq("y_vld", int'(yvld), int'(busy && cd == 0));
        if (busy && cd == 0) begin
            check_eq("y", int'(y), exp_y);
            check_eq("y_ch", int'(ych), exp_ch);
            if (yvld && yrdy) begin
                busy = 1'b0;
                res_log.push_back(int'(y));
            end else if (yvld && stall_left > 0) begin
                stall_left--;
                n_stall++;
            end
        end
        if (rdy != '0 && !busy) begin
            check_eq("rdy_onehot", $countones(rdy), 1);
            g = -1;
            for (int c = NCH - 1; c >= 0; c--) if (rdy[c]) g = c;
            check_eq("grant", g, pick(prev_vld));
            xs = (head[g] < tail[g]) ? sbuf[g][head[g]] : 0;
            check_eq("err", int'(err), int'(xs == 0));
            if (err && g == 1) n_err1++;
            mptr = (g + 1) % NCH;
            if (head[g] < tail[g]) consumed[g] = 1'b1;
            grant_log.push_back(g);
            if (xs != 0) begin
                mh[g][2] = mh[g][1];
                mh[g][1] = mh[g][0];
                mh[g][0] = xs;
                if (mk[g] < 3) mk[g]++;
                exp_y  = 50 * mh[g][0] + 31 * mh[g][1] + 63 * mh[g][2];
                exp_ch = g;
                cd     = mk[g] + 4;
                busy   = 1'b1;
                n_acc++;
                if (rand_stall) stall_left = $urandom_range(0, 3);
            end
        end else begin
            check_eq("err_idle", int'(err), 0);
        end
        prev_vld = vld;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) begin
            if (consumed[c]) begin
                head[c]++;
                consumed[c] = 1'b0;
            end
        end
        refresh();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            head[c] = 0;
            tail[c] = 0;
            consumed[c] = 1'b0;
            mk[c] = 0;
            for (int t = 0; t < 3; t++) mh[c][t] = 0;
        end
        stall_left = 0;
        busy = 1'b0;
        cd = 0;
        mptr = 0;
        refresh();
        @(negedge clk);
        check_eq("rst_rdy", int'(rdy), 0);
        check_eq("rst_y", int'(y), 0);
        check_eq("rst_y_ch", int'(ych), 0);
        check_eq("rst_y_vld", int'(yvld), 0);
        check_eq("rst_err", int'(err), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev_vld = vld;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while ((busy || pending()) && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, int'(busy || pending()), 0);
        tick();
        tick();
    endtask

    initial begin
        int gs;
        int acc0;
        int st0;
        int exp_res [4];
        int exp_gnt [4];

        do_reset();

        // first sample on ch0: single-entry history
        enqueue(0, 4);
        wait_done("job_4_done", 50);
        check_eq("first_4", last_res(), 200);

        // growing history on ch0
        enqueue(0, 2);
        wait_done("job_2_done", 50);
        check_eq("hist_2", last_res(), 224);
        enqueue(0, 3);
        wait_done("job_3_done", 50);
        check_eq("hist_3", last_res(), 464);

        // zero sample on ch1 is rejected, then a real one
        enqueue(1, 0);
        enqueue(1, 6);
        wait_done("ch1_done", 60);
        check_eq("ch1_err_pulses", n_err1, 1);
        check_eq("ch1_6", last_res(), 300);

        // result held for 10 cycles with i_y_rdy low
        stall_left = 10;
        st0 = n_stall;
        enqueue(0, 1);
        wait_done("stall_done", 80);
        check_eq("stall_len", n_stall - st0, 10);
        check_eq("stall_y", last_res(), 269);

        // reset while the core is being fed
        enqueue(0, 5);
        acc0 = n_acc;
        for (int i = 0; i < 20 && n_acc == acc0; i++) tick();
        check_eq("midjob_accept", n_acc - acc0, 1);
        tick();
        tick();
        do_reset();
        enqueue(0, 4);
        wait_done("after_rst_done", 50);
        check_eq("after_rst_4", last_res(), 200);

        // both channels requesting every cycle from reset
        do_reset();
        gs = res_log.size();
        acc0 = grant_log.size();
        enqueue(0, 5);
        enqueue(0, 5);
        enqueue(1, 7);
        enqueue(1, 7);
        wait_done("contend_done", 200);
`ifdef FIR_ARB_FIXED_PRIO_EN
        exp_res = '{250, 405, 350, 567};
        exp_gnt = '{0, 0, 1, 1};
`else
        exp_res = '{250, 350, 405, 567};
        exp_gnt = '{0, 1, 0, 1};
`endif
        check_eq("contend_count", res_log.size() - gs, 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("contend_res%0d", i),
                     (gs + i < res_log.size()) ? res_log[gs + i] : -1, exp_res[i]);
            check_eq($sformatf("contend_gnt%0d", i),
                     (acc0 + i < grant_log.size()) ? grant_log[acc0 + i] : -1, exp_gnt[i]);
        end

        // randomized traffic with random result back-pressure
        do_reset();
        rand_stall = 1'b1;
        for (int i = 0; i < 240; i++) begin
            if ($urandom_range(0, 3) == 0)
                enqueue(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 7)));
            tick();
        end
        wait_done("random_done", 2000);
        rand_stall = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_share_arb.md
FIR_SHARE_ARB -- requirements
Module: fir_share_arb

Interface
REQ-001 SHALL have parameter: NCH, default 2, number of requester channels (legal 2..4).
REQ-002 SHALL have port: i_clk  in  1  clock, rising edge.
REQ-003 SHALL have port: i_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: i_vld  in  NCH  per-channel sample valid.
REQ-005 SHALL have port: i_x  in  NCH x 3  per-channel unsigned sample, 1..7 legal; 0 is reserved.
REQ-006 SHALL have port: o_rdy  out  NCH  per-channel accept strobe; at most one bit high per cycle.
REQ-007 SHALL have port: o_y  out  12  filter result for the granted channel.
REQ-008 SHALL have port: o_y_ch  out  2  channel index of o_y.
REQ-009 SHALL have port: o_y_vld  out  1  result valid.
REQ-010 SHALL have port: i_y_rdy  in  1  result accept; transfer on o_y_vld & i_y_rdy.
REQ-011 SHALL have port: o_err  out  1  one-cycle pulse when a zero sample is rejected.

Function
REQ-012 SHALL time-share one FIR core, y = 50*x[n] + 31*x[n-1] + 63*x[n-2], with a 1-cycle registered output, across NCH channels.
- Each channel keeps a private 3-entry sample history plus a per-entry valid bit.
REQ-013 SHALL implement FSM states IDLE, CLR0, CLR1, FEED, CAP, RESP.
REQ-014 SHALL, in IDLE, grant one requesting channel round-robin, starting after the last granted channel.
- Raise o_rdy for that channel for exactly one cycle.
- Shift i_x into that channel's history.
- Go to CLR0.
REQ-015 SHALL drive core Xin = 0 in CLR0 and in CLR1, which fully clears the core taps.
REQ-016 SHALL, in FEED, drive that channel's valid history entries, oldest first, one per cycle, for k = 1..3 cycles.
- Missing entries are skipped and remain 0 in the core.
REQ-017 SHALL drive core Xin = 0 in every state except FEED.
REQ-018 SHALL, in CAP, register the core Yout into o_y and the channel index into o_y_ch, then go to RESP.
REQ-019 SHALL, in RESP, hold o_y_vld = 1 with o_y and o_y_ch stable until i_y_rdy = 1, then return to IDLE.
REQ-020 SHALL set latency: o_y_vld first high k+4 cycles after the accept cycle.
REQ-021 SHALL accept no new sample outside IDLE; o_rdy = 0 in all other states.
REQ-022 SHALL, on a granted sample equal to 0:
- pulse o_rdy and o_err in the same cycle;
- leave the history unchanged;
- produce no result;
- stay in IDLE.
REQ-023 SHALL give a channel whose i_vld is low no grant; the round-robin pointer advances only on a grant.

Reset
REQ-024 SHALL, on i_rst_n low:
- force IDLE;
- clear all histories and valid bits;
- clear the round-robin pointer to channel 0;
- set o_rdy = 0, o_y = 0, o_y_ch = 0, o_y_vld = 0, o_err = 0;
- reset the core, with core Xin = 0.
REQ-025 SHALL, on reset asserted mid-job (any non-IDLE state), abandon the job with no result and leave no residual core state.

Configuration
REQ-026 SHALL, with FIR_ARB_FIXED_PRIO_EN defined, grant the lowest-index requesting channel (channel 0 highest priority) instead of round-robin.
REQ-027 SHALL, without FIR_ARB_FIXED_PRIO_EN, use round-robin per REQ-014; all other behaviour is identical in both builds.

Structure
REQ-028 SHALL place the FSM state enum, the sample type (3-bit) and the result type (12-bit) in shared package fir_pkg.
REQ-029 SHALL instantiate FIR_Filter_Core as the single sub-module u_core; arbitration, history and the FSM stay in fir_share_arb.

Verification
REQ-030 SHALL cover: ch0 first sample 4, i_y_rdy = 1 -> o_y = 200, o_y_ch = 0, o_y_vld at accept+5.
REQ-031 SHALL cover: ch0 then sends 2, then 3 -> o_y = 224, then 464 (k = 3, o_y_vld at accept+7).
REQ-032 SHALL cover: ch0 and ch1 both valid every cycle, ch0 with 5, ch1 with 7, after reset.
- Expect grants alternating 0,1,0,1.
- Expect results 250, 350, 405, 567.
- With FIR_ARB_FIXED_PRIO_EN, expect ch0 granted every time.
REQ-033 SHALL cover: ch1 sends 0 -> o_err pulse with o_rdy[1], no o_y_vld, and ch1's next sample of 6 gives 300.
REQ-034 SHALL cover: i_y_rdy held low 10 cycles in RESP -> o_y stable, o_rdy = 0 throughout, and transfer on the cycle i_y_rdy rises.
REQ-035 SHALL cover: reset pulse during FEED -> all outputs 0 and histories cleared; the next ch0 sample of 4 gives 200.
